// File: rtl/rca_aproximado_pipe.sv
// Pipelined approximate ripple-carry adder: lower K bits OR-approximated, exact upper ripple.
// Latency 2 cycles, 1/cycle throughput; a stalled output freezes both stages, in_ready = !out_valid | out_ready.
// Define ERROR_STATS_EN to build the exact-sum shadow adder and the err_count/err_max statistics.
module rca_aproximado_pipe #(
   parameter int WIDTH = 8,
   parameter int K     = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             exact,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   S,
   input  logic             stats_clr,
   output logic [15:0]      err_count,
   output logic [WIDTH:0]   err_max
);

   function automatic logic [WIDTH-1:0] lo_mask_f();
      logic [WIDTH-1:0] m;
      for (int i = 0; i < WIDTH; i++) m[i] = (i < K);
      return m;
   endfunction

   localparam logic [WIDTH-1:0] LO_MASK = lo_mask_f();

   logic             advance;
   logic             ov_q;
   logic             v1;
   logic [WIDTH-1:0] lo1, ahi1, bhi1;
   logic             cin1;
   logic             cin_apx;
   logic [WIDTH-1:0] mask_d;
   logic [WIDTH:0]   cin_vec;
   logic [WIDTH:0]   sum2;

   assign advance   = !ov_q | out_ready;
   assign in_ready  = advance & !rst;
   assign out_valid = ov_q & !rst;

   generate
      if (K == 0) begin : g_nocarry
         assign cin_apx = 1'b0;
      end else begin : g_carry
         assign cin_apx = A[K-1] & B[K-1];
      end
   endgenerate

   // Exact mode simply collapses the approximate region to zero width.
   assign mask_d = exact ? '0 : LO_MASK;

   always_ff @(posedge clk) begin
      if (rst) begin
         v1   <= 1'b0;
         ov_q <= 1'b0;
         S    <= '0;
      end else if (advance) begin
         v1   <= in_valid;
         ov_q <= v1;
         if (v1) S <= sum2;
      end
   end

   always_ff @(posedge clk) begin
      if (advance && in_valid) begin
         lo1  <= (A | B) & mask_d;
         ahi1 <= A & ~mask_d;
         bhi1 <= B & ~mask_d;
         cin1 <= exact ? 1'b0 : cin_apx;
      end
   end

   // Upper slices have zeros below bit K, so the ripple sum leaves the OR bits untouched.
   assign cin_vec = {{WIDTH{1'b0}}, cin1} << K;
   assign sum2    = ({1'b0, ahi1} + {1'b0, bhi1} + cin_vec) | {1'b0, lo1};

`ifdef ERROR_STATS_EN
   logic [WIDTH:0] ex1, ex2;
   logic           e1, e2;
   logic [WIDTH:0] err;

   always_ff @(posedge clk) begin
      if (advance && in_valid) begin
         ex1 <= {1'b0, A} + {1'b0, B};
         e1  <= exact;
      end
      if (advance && v1) begin
         ex2 <= ex1;
         e2  <= e1;
      end
   end

   assign err = (ex2 > S) ? (ex2 - S) : (S - ex2);

   always_ff @(posedge clk) begin
      if (rst || stats_clr) begin
         err_count <= '0;
         err_max   <= '0;
      end else if (out_valid && out_ready && !e2) begin
         if (err != '0 && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
         if (err > err_max) err_max <= err;
      end
   end
`else
   logic unused_stats_clr;
   assign unused_stats_clr = stats_clr;
   assign err_count        = '0;
   assign err_max          = '0;
`endif

endmodule

// File: tb/tb_rca_aproximado_pipe.sv
// Scoreboard bench for rca_aproximado_pipe: three instances (K=3, K=0, K=8) share one stimulus stream.
module tb_rca_aproximado_pipe;

   typedef struct {
      logic [8:0] s;
      logic [8:0] ex;
      logic       e;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       exact = 1'b0;
   logic       out_ready = 1'b1;
   logic       stats_clr = 1'b0;
   logic [7:0] a = '0, b = '0;
   logic       rand_rdy = 1'b0;

   logic        ir0, ov0, ov1, ov2;
   logic        ir_unused1, ir_unused2;
   logic [8:0]  s0, s1, s2;
   logic [15:0] ec0, ec_unused1, ec_unused2;
   logic [8:0]  em0, em_unused1, em_unused2;

   exp_t q0[$], q1[$], q2[$];
   int checks = 0, errors = 0;
   int mcnt = 0, mmax = 0;
   logic [8:0] held;
   logic held_vld = 1'b0;

   always #5 clk = ~clk;

   rca_aproximado_pipe #(.WIDTH(8), .K(3)) u0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0), .A(a), .B(b), .exact(exact),
      .out_valid(ov0), .out_ready(out_ready), .S(s0), .stats_clr(stats_clr),
      .err_count(ec0), .err_max(em0));
   rca_aproximado_pipe #(.WIDTH(8), .K(0)) u1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_unused1), .A(a), .B(b), .exact(exact),
      .out_valid(ov1), .out_ready(out_ready), .S(s1), .stats_clr(stats_clr),
      .err_count(ec_unused1), .err_max(em_unused1));
   rca_aproximado_pipe #(.WIDTH(8), .K(8)) u2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_unused2), .A(a), .B(b), .exact(exact),
      .out_valid(ov2), .out_ready(out_ready), .S(s2), .stats_clr(stats_clr),
      .err_count(ec_unused2), .err_max(em_unused2));

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference: low k bits are a|b, carry a[k-1]&b[k-1] feeds an exact add of the high parts.
   function automatic logic [8:0] model(input logic [7:0] x, input logic [7:0] y, input logic e, input int k);
      int unsigned xa, ya, lo, hi, c;
      xa = x;
      ya = y;
      if (e || k == 0) return 9'(xa + ya);
      lo = (xa | ya) & ((1 << k) - 1);
      c  = (xa >> (k - 1)) & (ya >> (k - 1)) & 1;
      hi = ((xa >> k) + (ya >> k) + c) << k;
      return 9'(hi | lo);
   endfunction

   always @(negedge clk) begin
      exp_t e;
      int   d;
      if (ov0 && out_ready) begin
         if (q0.size() == 0) begin
            checks++; errors++;
            $display("FAIL u0_unexpected_output: got S=%0h with empty scoreboard", s0);
         end else begin
            e = q0.pop_front();
            check("u0_S", 32'(s0), 32'(e.s));
`ifdef ERROR_STATS_EN
            if (!e.e) begin
               d = (e.ex > e.s) ? int'(e.ex) - int'(e.s) : int'(e.s) - int'(e.ex);
               if (d != 0 && mcnt < 65535) mcnt++;
               if (d > mmax) mmax = d;
            end
`endif
         end
      end
      if (ov0 && !out_ready) begin
         check("in_ready_stall", 32'(ir0), 32'd0);
         if (held_vld) check("S_hold", 32'(s0), 32'(held));
         held     = s0;
         held_vld = 1'b1;
      end else begin
         held_vld = 1'b0;
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (ov1 && out_ready) begin
         if (q1.size() == 0) begin
            checks++; errors++;
            $display("FAIL u1_unexpected_output: got S=%0h with empty scoreboard", s1);
         end else begin
            e = q1.pop_front();
            check("u1_K0_S", 32'(s1), 32'(e.s));
         end
      end
      if (ov2 && out_ready) begin
         if (q2.size() == 0) begin
            checks++; errors++;
            $display("FAIL u2_unexpected_output: got S=%0h with empty scoreboard", s2);
         end else begin
            e = q2.pop_front();
            check("u2_K8_S", 32'(s2), 32'(e.s));
         end
      end
   end

   always @(posedge clk) begin
      if (rand_rdy) begin
         #1 out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic send(input logic [7:0] x, input logic [7:0] y, input logic e);
      int n = 0;
      exp_t t;
      in_valid = 1'b1;
      a = x;
      b = y;
      exact = e;
      @(negedge clk);
      while (!ir0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!ir0) begin
         checks++; errors++;
         $display("FAIL send_timeout: in_ready stuck at %0b, required 1", ir0);
      end else begin
         t.ex = 9'({1'b0, x} + {1'b0, y});
         t.e  = e;
         t.s  = model(x, y, e, 3); q0.push_back(t);
         t.s  = model(x, y, e, 0); q1.push_back(t);
         t.s  = model(x, y, e, 8); q2.push_back(t);
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((q0.size() != 0 || q1.size() != 0 || q2.size() != 0) && n < 1000) begin
         @(posedge clk);
         n++;
      end
      if (q0.size() != 0 || q1.size() != 0 || q2.size() != 0) begin
         checks++; errors++;
         $display("FAIL drain_timeout: %0d results outstanding, required 0", q0.size());
      end
      #1;
   endtask

   task automatic check_stats(input string nm);
      @(negedge clk);
      check({nm, "_err_count"}, 32'(ec0), 32'(mcnt));
      check({nm, "_err_max"}, 32'(em0), 32'(mmax));
      @(posedge clk);
      #1;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("reset_out_valid", 32'(ov0), 32'd0);
      check("reset_S", 32'(s0), 32'd0);
      check("reset_err_count", 32'(ec0), 32'd0);
      check("reset_err_max", 32'(em0), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("in_ready_after_reset", 32'(ir0), 32'd1);
      @(posedge clk);
      #1;

      // Single approximate transaction with latency check.
      send(8'h0F, 8'h01, 1'b0);
      @(negedge clk);
      check("latency_cycle1_out_valid", 32'(ov0), 32'd0);
      @(negedge clk);
      check("latency_cycle2_out_valid", 32'(ov0), 32'd1);
      check("latency_cycle2_S", 32'(s0), 32'h00F);
      drain();
      check_stats("t1");

      send(8'h04, 8'h04, 1'b0);
      send(8'hFF, 8'hFF, 1'b0);
      drain();
      check_stats("t2");

      send(8'hFF, 8'hFF, 1'b1);
      drain();
      check_stats("t3_exact");

      // Six back-to-back with a three-cycle output stall.
      fork
         begin
            for (int i = 0; i < 6; i++) send(8'(i * 37 + 5), 8'(i * 91 + 3), 1'(i % 2));
         end
         begin
            repeat (2) @(posedge clk);
            #1 out_ready = 1'b0;
            repeat (3) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      drain();
      check_stats("t4_stall");

      // stats_clr coinciding with an erroring update: clear must win.
      send(8'h04, 8'h04, 1'b0);
      @(posedge clk);
      #1 stats_clr = 1'b1;
      @(posedge clk);
      #1 stats_clr = 1'b0;
      mcnt = 0;
      mmax = 0;
      drain();
      check_stats("t5_clr");

      // Reset with two transactions in flight.
      send(8'h0F, 8'h01, 1'b0);
      drain();
      send(8'h11, 8'h22, 1'b0);
      send(8'h33, 8'h44, 1'b0);
      rst = 1'b1;
      q0.delete();
      q1.delete();
      q2.delete();
      @(negedge clk);
      check("rst_cycle_out_valid", 32'(ov0), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      mcnt = 0;
      mmax = 0;
      @(negedge clk);
      check("post_rst_out_valid", 32'(ov0), 32'd0);
      repeat (4) @(posedge clk);
      #1;
      check_stats("t6_rst");

      // Random traffic with random backpressure and idle gaps.
      rand_rdy = 1'b1;
      for (int i = 0; i < 300; i++) begin
         send(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 4) == 0) begin
            @(posedge clk);
            #1;
         end
      end
      rand_rdy = 1'b0;
      @(posedge clk);
      #2 out_ready = 1'b1;
      drain();
      check_stats("t7_random");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
